bcd_uart_printer: RTL
=====================

Name: bcd_uart_printer

Overview:
- Sequencer that sits directly downstream of message_rom and upstream of the UART transmitter.
- On a print request it latches a 32-bit value, drives it to message_rom, and pulses startconv. It then waits for conversiondone.
- Next it walks addr from the most-significant digit (10) down to 1, then addr 11 (newline), pushing each ROM byte into serial_tx with a new_data/busy handshake. Optional leading-zero suppression.

Parameters:
- SUPPRESS_ZEROS, 1, 1 = skip leading "0" characters (the last digit, addr 1, is always sent).
- ROM_WAIT, 2, settle cycles between an addr change and sampling rom_data (message_rom output is registered).
- CONV_TIMEOUT, 1023, cycles to wait for conversiondone before aborting with err.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  print request, sampled only in IDLE
- value  in  32  value to print, latched on accepted go
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the newline is handed to the UART, or on abort
- err  out  1  sticky conversion-timeout flag, cleared on the next accepted go
- rom_value  out  32  latched value, to message_rom valuetoprint
- rom_start  out  1  to message_rom startconv
- rom_addr  out  4  to message_rom addr
- rom_data  in  8  from message_rom data
- rom_done  in  1  from message_rom conversiondone
- tx_data  out  8  byte to serial_tx
- tx_new  out  1  to serial_tx new_data, one-cycle strobe
- tx_busy  in  1  from serial_tx busy

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, err=0, rom_start=0, tx_new=0.
  - rom_addr=0, rom_value=0, tx_data=0.
  - All counters cleared.
  - Reset mid-print abandons the print immediately; a partially sent line is not completed.
- All outputs are registered.
- IDLE:
  - On go=1, latch value into rom_value, clear err, and go to START.
  - go while busy is ignored; it is not queued.
- START:
  - rom_start=1 for exactly one cycle, then go to WAIT_CONV.
  - rom_start must never be held high: message_rom re-enters its idle state if startconv is high while conversiondone is low.
- WAIT_CONV:
  - Counts cycles. On rom_done=1, set rom_addr=10, set leading=SUPPRESS_ZEROS, and go to WAIT_ROM.
  - If count reaches CONV_TIMEOUT: err=1, done pulse, go to IDLE.
  - rom_done arriving in the same cycle the count reaches CONV_TIMEOUT counts as success.
- WAIT_ROM:
  - Hold rom_addr for ROM_WAIT cycles, then sample rom_data into tx_data and go to DECIDE.
- DECIDE:
  - Skip the byte if leading=1, tx_data=="0" (8'h30) and rom_addr>1; go to NEXT.
  - Otherwise clear leading and go to SEND.
  - Any non-"0" byte (including "\n") clears leading.
- SEND:
  - Wait until tx_busy=0, then assert tx_new=1 for one cycle with tx_data stable; go to WAIT_TX.
- WAIT_TX:
  - Ignore tx_busy in the first cycle (serial_tx raises busy one cycle after new_data).
  - Then wait for tx_busy=0 and go to NEXT.
  - tx_data holds its value until the next SEND.
- NEXT:
  - rom_addr 10..2: decrement and go to WAIT_ROM.
  - rom_addr 1: set 11 and go to WAIT_ROM.
  - rom_addr 11: done pulse, rom_addr=0, go to IDLE.
- Character count per print:
  - SUPPRESS_ZEROS=0: always 11 bytes (10 digits plus "\n").
  - SUPPRESS_ZEROS=1: significant digits plus "\n"; minimum 2 bytes.
- done and err never assert in the same cycle except on timeout.
- A go arriving in the done cycle is not accepted; it is accepted from the following IDLE cycle on.

Test Plan:
- SUPPRESS_ZEROS=0, value=32'd1234, tx_busy model of 10 cycles per byte -> UART receives "0000001234\n" (11 bytes) in order. Exactly one done pulse. err=0. rom_start high for exactly 1 cycle.
- SUPPRESS_ZEROS=1, value=32'd0 -> bytes "0","\n" only. value=32'd4294967295 -> "4294967295\n". value=32'd100 -> "100\n" (inner zeros kept).
- Backpressure: tx_busy held high for 200 cycles before the first byte -> tx_new is not asserted until tx_busy falls. No byte lost or duplicated. tx_data is stable while tx_new=1.
- Timeout: rom_done never asserted, CONV_TIMEOUT=16 -> err=1 and a done pulse 16 cycles after WAIT_CONV entry. No tx_new. A following go clears err and prints normally.
- go asserted continuously during a print of value=32'd7 -> single line "7\n". A second print starts only after returning to IDLE, with the newly latched value.
- rst_n pulsed low mid-line (after 3 bytes sent) -> all outputs return to reset values asynchronously. No further tx_new. The next go prints the full line from addr 10.

Source files
------------

// File: rtl/bcd_uart_printer.sv
// bcd_uart_printer
// Prints a 32-bit value as a decimal text line over a UART. The latched value
// is handed to message_rom for binary-to-BCD conversion, then the ten digit
// characters (most significant first) and a trailing newline are read back one
// address at a time and pushed into serial_tx using its new_data/busy
// handshake. Leading "0" characters can optionally be suppressed, but the
// units digit is always sent.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   go         print request, only looked at while idle
//   value      value to print, captured when go is accepted
//   busy       high whenever a print is in progress
//   done       one-cycle pulse at the end of a line or on a timeout abort
//   err        sticky conversion-timeout flag, cleared by the next accepted go
//   rom_value  captured value, to message_rom valuetoprint
//   rom_start  one-cycle conversion start strobe to message_rom
//   rom_addr   character address to message_rom (10..1 digits, 11 newline)
//   rom_data   character byte from message_rom (registered output)
//   rom_done   conversion-complete indication from message_rom
//   tx_data    byte presented to serial_tx
//   tx_new     one-cycle new_data strobe to serial_tx
//   tx_busy    busy indication from serial_tx

module bcd_uart_printer #(
   parameter int SUPPRESS_ZEROS = 1,
   parameter int ROM_WAIT       = 2,
   parameter int CONV_TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [31:0] value,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rom_value,
   output logic        rom_start,
   output logic [3:0]  rom_addr,
   input  logic [7:0]  rom_data,
   input  logic        rom_done,
   output logic [7:0]  tx_data,
   output logic        tx_new,
   input  logic        tx_busy
);

   localparam int CNT_W  = (CONV_TIMEOUT < 2) ? 1 : $clog2(CONV_TIMEOUT);
   localparam int WAIT_W = (ROM_WAIT < 2) ? 1 : $clog2(ROM_WAIT);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((CONV_TIMEOUT < 1) ? 0 : CONV_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ROM_WAIT < 1) ? 0 : ROM_WAIT - 1);
   localparam logic              LEAD_INIT = (SUPPRESS_ZEROS != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_CONV,
      S_WAIT_ROM,
      S_DECIDE,
      S_SEND,
      S_WAIT_TX,
      S_NEXT
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    conv_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                leading;
   logic                tx_first;

   // Whole print sequence in one registered state machine. Strobes (rom_start,
   // tx_new, done) default low every cycle so they can only ever be one cycle
   // wide. The conversion counter counts WAIT_CONV cycles; rom_done is tested
   // before the timeout so a completion on the final counted cycle still wins.
   // WAIT_ROM holds the address long enough for the registered ROM output to
   // reflect it before it is copied into tx_data. The first WAIT_TX cycle
   // ignores tx_busy because serial_tx only raises busy one cycle after the
   // strobe. go is refused while done is high so a held request cannot
   // restart in the same cycle the previous line finishes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rom_value <= '0;
         rom_start <= 1'b0;
         rom_addr  <= '0;
         tx_data   <= '0;
         tx_new    <= 1'b0;
         conv_cnt  <= '0;
         wait_cnt  <= '0;
         leading   <= 1'b0;
         tx_first  <= 1'b0;
      end else begin
         rom_start <= 1'b0;
         tx_new    <= 1'b0;
         done      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go && !done) begin
                  rom_value <= value;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_START;
               end
            end
            S_START: begin
               rom_start <= 1'b1;
               conv_cnt  <= '0;
               state     <= S_WAIT_CONV;
            end
            S_WAIT_CONV: begin
               if (rom_done) begin
                  rom_addr <= 4'd10;
                  leading  <= LEAD_INIT;
                  wait_cnt <= '0;
                  state    <= S_WAIT_ROM;
               end else if (conv_cnt == CNT_LAST) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  conv_cnt <= conv_cnt + CNT_W'(1);
               end
            end
            S_WAIT_ROM: begin
               if (wait_cnt == WAIT_LAST) begin
                  tx_data <= rom_data;
                  state   <= S_DECIDE;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_DECIDE: begin
               if (leading && (tx_data == 8'h30) && (rom_addr > 4'd1)) begin
                  state <= S_NEXT;
               end else begin
                  leading <= 1'b0;
                  state   <= S_SEND;
               end
            end
            S_SEND: begin
               if (!tx_busy) begin
                  tx_new   <= 1'b1;
                  tx_first <= 1'b1;
                  state    <= S_WAIT_TX;
               end
            end
            S_WAIT_TX: begin
               if (tx_first) begin
                  tx_first <= 1'b0;
               end else if (!tx_busy) begin
                  state <= S_NEXT;
               end
            end
            S_NEXT: begin
               wait_cnt <= '0;
               if (rom_addr == 4'd11) begin
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  rom_addr <= 4'd0;
                  state    <= S_IDLE;
               end else if (rom_addr == 4'd1) begin
                  rom_addr <= 4'd11;
                  state    <= S_WAIT_ROM;
               end else begin
                  rom_addr <= rom_addr - 4'd1;
                  state    <= S_WAIT_ROM;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
